// File: rtl/seq_frame_tx_if.sv
// Handshake and serial-line bundle for the sync-pattern frame transmitter.
interface seq_frame_tx_if #(
   parameter int DATA_W = 8
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              tx_bit;
   logic              tx_active;
   logic              done;

   modport master (
      output in_valid,
      output in_data,
      input  in_ready,
      input  tx_bit,
      input  tx_active,
      input  done
   );

   modport slave (
      input  in_valid,
      input  in_data,
      output in_ready,
      output tx_bit,
      output tx_active,
      output done
   );
endinterface

// File: rtl/seq_frame_tx.sv
// Serial frame transmitter: sync header, then payload MSB first, one bit per clock.
// Optional trailing even-parity bit when the PARITY_EN macro is defined.
module seq_frame_tx #(
   parameter int                  DATA_W       = 8,
   parameter int                  SYNC_LEN     = 5,
   parameter logic [SYNC_LEN-1:0] SYNC_PATTERN = 5'b10110,
   parameter logic                IDLE_BIT     = 1'b0
) (
   input  logic          clk,
   input  logic          rst,
   seq_frame_tx_if.slave bus
);

   localparam int CNT_MAX = (SYNC_LEN > DATA_W) ? SYNC_LEN : DATA_W;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_LEN - 1);
   localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SYNC = 2'd1,
      ST_DATA = 2'd2
`ifdef PARITY_EN
      ,
      ST_PAR  = 2'd3
`endif
   } state_t;

`ifdef PARITY_EN
   function automatic logic even_parity(input logic [DATA_W-1:0] word);
      even_parity = ^word;
   endfunction
`endif

   state_t            state_r;
   state_t            state_nx_s;
   logic [CNT_W-1:0]  cnt_r;
   logic [CNT_W-1:0]  cnt_nx_s;
   logic [DATA_W-1:0] shift_r;
   logic [DATA_W-1:0] shift_nx_s;
   logic              tx_bit_r;
   logic              tx_bit_nx_s;
   logic              tx_active_r;
   logic              tx_active_nx_s;
   logic              done_r;
   logic              done_nx_s;
`ifdef PARITY_EN
   logic              par_r;
   logic              par_nx_s;
`endif

   assign bus.in_ready  = (state_r == ST_IDLE);
   assign bus.tx_bit    = tx_bit_r;
   assign bus.tx_active = tx_active_r;
   assign bus.done      = done_r;

   // Next-state logic; line outputs are derived from the next state so they register in step with it.
   always_comb begin
      state_nx_s     = state_r;
      cnt_nx_s       = cnt_r;
      shift_nx_s     = shift_r;
      tx_bit_nx_s    = IDLE_BIT;
      tx_active_nx_s = 1'b0;
`ifdef PARITY_EN
      par_nx_s       = par_r;
`endif

      case (state_r)
         ST_IDLE: begin
            if (bus.in_valid) begin
               state_nx_s = ST_SYNC;
               cnt_nx_s   = SYNC_LAST;
               shift_nx_s = bus.in_data;
`ifdef PARITY_EN
               par_nx_s   = even_parity(bus.in_data);
`endif
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         ST_SYNC: begin
            if (cnt_r == CNT_ZERO) begin
               state_nx_s = ST_DATA;
               cnt_nx_s   = DATA_LAST;
            end else begin
               cnt_nx_s   = cnt_r - CNT_ONE;
            end
         end
         ST_DATA: begin
            // The first data cycle shows the unshifted MSB, so shifting starts only while already in DATA.
            shift_nx_s = shift_r << 1;
            if (cnt_r == CNT_ZERO) begin
`ifdef PARITY_EN
               state_nx_s = ST_PAR;
`else
               state_nx_s = ST_IDLE;
`endif
            end else begin
               cnt_nx_s   = cnt_r - CNT_ONE;
            end
         end
`ifdef PARITY_EN
         ST_PAR: begin
            state_nx_s = ST_IDLE;
         end
`endif
         default: begin
            state_nx_s = ST_IDLE;
            cnt_nx_s   = CNT_ZERO;
         end
      endcase

      case (state_nx_s)
         ST_SYNC: begin
            tx_bit_nx_s    = SYNC_PATTERN[cnt_nx_s];
            tx_active_nx_s = 1'b1;
         end
         ST_DATA: begin
            tx_bit_nx_s    = shift_nx_s[DATA_W-1];
            tx_active_nx_s = 1'b1;
         end
`ifdef PARITY_EN
         ST_PAR: begin
            tx_bit_nx_s    = par_nx_s;
            tx_active_nx_s = 1'b1;
         end
`endif
         default: begin
            tx_bit_nx_s    = IDLE_BIT;
            tx_active_nx_s = 1'b0;
         end
      endcase

      done_nx_s = (state_nx_s == ST_IDLE) && (state_r != ST_IDLE);
   end

   // State, datapath and registered line outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         cnt_r       <= CNT_ZERO;
         shift_r     <= {DATA_W{1'b0}};
         tx_bit_r    <= IDLE_BIT;
         tx_active_r <= 1'b0;
         done_r      <= 1'b0;
`ifdef PARITY_EN
         par_r       <= 1'b0;
`endif
      end else begin
         state_r     <= state_nx_s;
         cnt_r       <= cnt_nx_s;
         shift_r     <= shift_nx_s;
         tx_bit_r    <= tx_bit_nx_s;
         tx_active_r <= tx_active_nx_s;
         done_r      <= done_nx_s;
`ifdef PARITY_EN
         par_r       <= par_nx_s;
`endif
      end
   end

endmodule

// File: tb/tb_seq_frame_tx.sv
// Self-checking bench for seq_frame_tx: directed test-plan steps plus randomized traffic
// checked against a queue-based model of the line. Honours PARITY_EN like the design.
module tb_seq_frame_tx;

   typedef struct packed {
      logic b;   // tx_bit
      logic a;   // tx_active
      logic d;   // done
   } line_t;

`ifdef PARITY_EN
   localparam int FRAME_LEN = 14;
`else
   localparam int FRAME_LEN = 13;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_assert = 0;
   int   n_fail   = 0;

   line_t       exp_q[$];
   line_t       cur;
   logic [4:0]  sync_pat;
   logic [15:0] cap;
   int          cap_n;

   seq_frame_tx_if #(.DATA_W(8)) bus ();

   seq_frame_tx dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: a frame is the sync header, the word MSB first, optional parity, then a done cycle.
   task automatic model_edge(input logic v, input logic [7:0] d, input logic r);
      logic ready;
      ready = !cur.a;
      if (r) begin
         exp_q.delete();
         cur = '{b: 1'b0, a: 1'b0, d: 1'b0};
      end else begin
         if (v && ready) begin
            for (int i = 4; i >= 0; i--) exp_q.push_back('{b: sync_pat[i], a: 1'b1, d: 1'b0});
            for (int i = 7; i >= 0; i--) exp_q.push_back('{b: d[i], a: 1'b1, d: 1'b0});
`ifdef PARITY_EN
            exp_q.push_back('{b: ^d, a: 1'b1, d: 1'b0});
`endif
            exp_q.push_back('{b: 1'b0, a: 1'b0, d: 1'b1});
         end
         if (exp_q.size() > 0) cur = exp_q.pop_front();
         else cur = '{b: 1'b0, a: 1'b0, d: 1'b0};
      end
   endtask

   task automatic step(input logic v, input logic [7:0] d, input logic r);
      bus.in_valid = v;
      bus.in_data  = d;
      rst          = r;
      @(posedge clk);
      model_edge(v, d, r);
      @(negedge clk);
      chk("tx_bit",    bus.tx_bit,    cur.b);
      chk("tx_active", bus.tx_active, cur.a);
      chk("done",      bus.done,      cur.d);
      chk("in_ready",  bus.in_ready,  !cur.a);
      if (bus.tx_active === 1'b1) begin
         cap   = {cap[14:0], bus.tx_bit};
         cap_n++;
      end
   endtask

   task automatic cap_clear();
      cap   = 16'h0000;
      cap_n = 0;
   endtask

   initial begin
      logic [15:0] exp_bits;
      sync_pat     = 5'b10110;
      cur          = '{b: 1'b0, a: 1'b0, d: 1'b0};
      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;
      cap_clear();

      // Reset, then ten idle cycles.
      step(1'b0, 8'h00, 1'b1);
      chk("rst_ready", bus.in_ready, 1'b1);
      repeat (10) step(1'b0, 8'h00, 1'b0);

      // A5 with in_data changed to 3C right after the accept.
      cap_clear();
      step(1'b1, 8'hA5, 1'b0);
      repeat (FRAME_LEN) step(1'b0, 8'h3C, 1'b0);
`ifdef PARITY_EN
      exp_bits = 16'b00_10110101001010;
`else
      exp_bits = 16'b000_1011010100101;
`endif
      chk("a5_len",   cap_n, FRAME_LEN);
      chk("a5_bits",  cap, exp_bits);
      chk("a5_done",  bus.done, 1'b1);
      chk("a5_ready", bus.in_ready, 1'b1);
      step(1'b0, 8'h00, 1'b0);
      chk("a5_done_1cyc", bus.done, 1'b0);

      // FF then 00 with in_valid held high.
      step(1'b1, 8'hFF, 1'b0);
      repeat (FRAME_LEN) step(1'b1, 8'hFF, 1'b0);
      chk("b2b_gap_bit", bus.tx_bit, 1'b0);
      chk("b2b_gap_done", bus.done, 1'b1);
      cap_clear();
      step(1'b1, 8'h00, 1'b0);
      repeat (FRAME_LEN) step(1'b0, 8'h00, 1'b0);
`ifdef PARITY_EN
      exp_bits = 16'b00_10110000000000;
`else
      exp_bits = 16'b000_1011000000000;
`endif
      chk("b2b_bits", cap, exp_bits);
      chk("b2b_done", bus.done, 1'b1);

      // Reset during the third payload bit of A5.
      step(1'b0, 8'h00, 1'b0);
      step(1'b1, 8'hA5, 1'b0);
      repeat (7) step(1'b0, 8'h00, 1'b0);
      chk("abort_pre_bit", bus.tx_bit, 1'b1);
      step(1'b0, 8'h00, 1'b1);
      chk("abort_bit",    bus.tx_bit,    1'b0);
      chk("abort_active", bus.tx_active, 1'b0);
      chk("abort_ready",  bus.in_ready,  1'b1);
      repeat (8) begin
         step(1'b0, 8'h00, 1'b0);
         chk("abort_no_done", bus.done, 1'b0);
      end
      cap_clear();
      step(1'b1, 8'h01, 1'b0);
      repeat (FRAME_LEN) step(1'b0, 8'h00, 1'b0);
`ifdef PARITY_EN
      exp_bits = 16'b00_10110000000011;
`else
      exp_bits = 16'b000_1011000000001;
`endif
      chk("post_abort_bits", cap, exp_bits);

      // 07: odd number of ones.
      cap_clear();
      step(1'b1, 8'h07, 1'b0);
      repeat (FRAME_LEN) step(1'b0, 8'h00, 1'b0);
`ifdef PARITY_EN
      exp_bits = 16'b00_10110000001111;
`else
      exp_bits = 16'b000_1011000000111;
`endif
      chk("w07_bits", cap, exp_bits);
      chk("w07_done", bus.done, 1'b1);

      // Randomized traffic with occasional resets.
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0,
              8'($urandom_range(0, 255)),
              ($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0);
      end
      repeat (FRAME_LEN + 2) step(1'b0, 8'h00, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/seq_frame_tx.md
Name: seq_frame_tx

Overview:
Serial frame transmitter for the 10110 sync-pattern link. Accepts one parallel payload word per valid/ready handshake and drives one bit per clock on tx_bit: a fixed sync header first (default 10110), then the payload MSB first. It sits at the transmit end of the serial link and feeds the sync-pattern detector on the receive side.

Parameters:
DATA_W, 8, payload width in bits (>=1)
SYNC_LEN, 5, sync header length in bits (>=1)
SYNC_PATTERN, 5'b10110, sync header; bit SYNC_LEN-1 is sent first
IDLE_BIT, 1'b0, line level driven when no frame is in flight

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  reset, synchronous, active-high
in_valid  input  1  payload word offered
in_ready  output  1  block can accept a word; equals (state==IDLE)
in_data  input  DATA_W  payload word; sampled only on handshake
tx_bit  output  1  serial line, registered
tx_active  output  1  high while a sync, data or parity bit is on tx_bit; registered
done  output  1  one-cycle pulse in the first idle cycle after a frame; registered

Behaviour:
- Reset, rst high at a rising edge: state=IDLE, tx_bit=IDLE_BIT, tx_active=0, done=0, bit counter=0, shift register=0. in_ready=1 in the cycle after the reset edge.
- Reset mid-frame aborts the frame immediately. Remaining bits are never sent, and done is not pulsed.
- Handshake: an accept occurs on an edge where in_valid && in_ready. in_data is latched into the shift register on that edge. in_data and in_valid are don't-care at all other times.
- FSM states:
  - IDLE: tx_bit=IDLE_BIT, tx_active=0. On accept, go to SYNC with counter=SYNC_LEN-1.
  - SYNC: tx_bit=SYNC_PATTERN[counter]. Counter decrements each cycle. At counter 0, go to DATA with counter=DATA_W-1.
  - DATA: tx_bit=shift register MSB, shifting left each cycle. At counter 0, go to IDLE; go to PAR instead when PARITY_EN is defined.
  - PAR: present only when PARITY_EN is defined. One cycle, then go to IDLE.
- Latency: the first sync bit appears on tx_bit in the cycle immediately after the accept edge.
- Frame length: SYNC_LEN+DATA_W cycles with tx_active=1; one more cycle when PARITY_EN is defined.
- done: asserted in the first IDLE cycle after the last frame bit, for exactly one cycle.
- Back-to-back frames: in_ready=1 in the same cycle as done. An accept there starts the next frame on the following cycle, giving a minimum inter-frame gap of exactly one IDLE_BIT cycle.
- in_valid held high continuously produces frames with one-cycle gaps and no lost words.
- in_ready=0 in SYNC, DATA and PAR. in_valid in those states is ignored, and the upstream must hold its word until accepted.
- Counter width: $clog2 of max(SYNC_LEN,DATA_W), minimum 1. The counter never wraps below 0, because the state changes at 0.
- Outputs never go X after the first reset. Behaviour before the first reset is undefined.

Optional Feature:
Macro PARITY_EN.
- Defined:
  - Even parity (XOR of the latched word) is computed at accept.
  - It is sent as one extra bit after the payload LSB, in state PAR, with tx_active=1.
  - done moves one cycle later.
- Not defined:
  - PAR state and parity logic are absent.
  - The frame ends after the payload LSB.

Test Plan:
- Reset, then 10 idle cycles with in_valid=0 -> tx_bit=0, tx_active=0, done=0, in_ready=1 every cycle.
- Accept in_data=8'hA5 -> tx_bit over the next 13 cycles: 1,0,1,1,0,1,0,1,0,0,1,0,1, with tx_active=1 throughout.
  - In cycle 14: tx_active=0, done=1, in_ready=1.
  - With PARITY_EN: bit 14 = 0, and done moves to cycle 15.
- in_valid held high with words 8'hFF then 8'h00:
  - Frames are separated by exactly one cycle of tx_bit=0.
  - in_ready is low for the 13 frame cycles.
  - Second frame bits: 1,0,1,1,0 followed by eight 0s.
  - With PARITY_EN: parity bit 0 for 8'hFF and 0 for 8'h00.
- Change in_data to 8'h3C in the cycle after accepting 8'hA5 -> the payload on the line is still A5.
- Assert rst during the 3rd payload bit of 8'hA5 -> next cycle tx_bit=0, tx_active=0, in_ready=1, and done is never pulsed.
  - A new accept of 8'h01 afterwards sends a clean 1,0,1,1,0,0,0,0,0,0,0,0,1.
- With PARITY_EN, accept 8'h07 -> the 14th active bit is 1, and done follows on the next cycle.
